// File: rtl/uart_tx_fifo.sv
// 8N1 UART transmitter fed by a power-of-two byte FIFO.
// A new frame starts in the same cycle the previous stop bit ends, so back-to-back bytes go out with no idle gap.
module uart_tx_fifo #(
  parameter int unsigned CLKS_PER_BIT = 5208,
  parameter int unsigned FIFO_DEPTH   = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [7:0]                    tx_data,
  input  logic                          tx_valid,
  output logic                          tx_ready,
  output logic                          tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int BAUD_W = $clog2(CLKS_PER_BIT);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0]  DEPTH_C   = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

  logic [7:0]        fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  state_e            state_q, state_d;
  logic [BAUD_W-1:0] baud_q, baud_d;
  logic [2:0]        bit_q, bit_d;
  logic [7:0]        shift_q, shift_d;
  logic              tx_q, tx_d;
  logic              push, pop;
  logic              fifo_nonempty;
  logic              baud_done;

  assign tx_ready      = (count_q < DEPTH_C);
  assign push          = tx_valid && tx_ready;
  assign fifo_nonempty = (count_q != '0);
  assign baud_done     = (baud_q == BAUD_LAST);

  assign tx         = tx_q;
  assign busy       = (state_q != IDLE) || fifo_nonempty;
  assign fifo_count = count_q;

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        if (fifo_nonempty) begin
          pop     = 1'b1;
          shift_d = fifo_mem[rd_ptr_q];
          baud_d  = '0;
          bit_d   = '0;
          tx_d    = 1'b0;
          state_d = START;
        end
      end
      START: begin
        if (baud_done) begin
          baud_d  = '0;
          tx_d    = shift_q[0];
          state_d = DATA;
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      DATA: begin
        if (baud_done) begin
          baud_d = '0;
          if (bit_q == 3'd7) begin
            tx_d    = 1'b1;
            state_d = STOP;
          end else begin
            // tx_d takes the bit that becomes shift_q[0] after this shift.
            bit_d   = bit_q + 3'd1;
            shift_d = {1'b0, shift_q[7:1]};
            tx_d    = shift_q[1];
          end
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      STOP: begin
        if (baud_done) begin
          baud_d = '0;
          if (fifo_nonempty) begin
            pop     = 1'b1;
            shift_d = fifo_mem[rd_ptr_q];
            bit_d   = '0;
            tx_d    = 1'b0;
            state_d = START;
          end else begin
            tx_d    = 1'b1;
            state_d = IDLE;
          end
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      default: begin
        tx_d    = 1'b1;
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      baud_q   <= '0;
      bit_q    <= '0;
      tx_q     <= 1'b1;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      tx_q     <= tx_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Datapath storage carries no reset; a stale byte is never visible because count_q gates every read.
  always_ff @(posedge clk) begin
    shift_q <= shift_d;
    if (push) fifo_mem[wr_ptr_q] <= tx_data;
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Scoreboard bench for uart_tx_fifo: a small instance (16 clk/bit, 4 entries) checked by a line monitor,
// plus a default-parameter instance timed against the 9600-baud bit period.
`timescale 1ns/1ps
module tb_uart_tx_fifo;

  localparam int CPB   = 16;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk;
  logic          rst;
  logic [7:0]    tx_data;
  logic          tx_valid;
  logic          tx_ready;
  logic          tx;
  logic          busy;
  logic [CW-1:0] fifo_count;

  logic          rst2;
  logic [7:0]    tx_data2;
  logic          tx_valid2;
  logic          tx_ready2;
  logic          tx2;
  logic          busy2;
  logic [4:0]    fifo_count2;

  int         n_chk = 0;
  int         n_fail = 0;
  int         cyc = 0;
  logic [7:0] exp_q[$];
  int         starts[$];
  bit         mon_act = 1'b0;

  uart_tx_fifo #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .tx(tx), .busy(busy), .fifo_count(fifo_count)
  );

  uart_tx_fifo dut_def (
    .clk(clk), .rst(rst2), .tx_data(tx_data2), .tx_valid(tx_valid2),
    .tx_ready(tx_ready2), .tx(tx2), .busy(busy2), .fifo_count(fifo_count2)
  );

  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
    $fatal(1, "time limit");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name, input int waited);
    n_chk++;
    n_fail++;
    $display("FAIL %s: no response after %0d cycles (cycle %0d)", name, waited, cyc);
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic send(input logic [7:0] b, input int max_wait, output int acc);
    acc      = -1;
    tx_data  = b;
    tx_valid = 1'b1;
    for (int w = 0; w < max_wait; w++) begin
      if (tx_ready === 1'b1) begin
        acc = cyc + 1;
        exp_q.push_back(b);
        @(negedge clk);
        break;
      end
      @(negedge clk);
    end
    tx_valid = 1'b0;
    if (acc < 0) fail_now("send_accept", max_wait);
  endtask

  task automatic wait_idle(input int max_cyc);
    int w;
    w = 0;
    while ((busy !== 1'b0 || mon_act) && w < max_cyc) begin
      @(negedge clk);
      w++;
    end
    if (w >= max_cyc) fail_now("wait_idle", max_cyc);
  endtask

  task automatic wait_tx2(input logic lvl, input int max_cyc, output longint t);
    int w;
    w = 0;
    while (tx2 !== lvl && w < max_cyc) begin
      @(negedge clk);
      w++;
    end
    if (w >= max_cyc) fail_now("tx2_edge", max_cyc);
    t = longint'($time);
  endtask

  // Line monitor: every sample of a frame is compared with the expected waveform, and mid-bit samples are decoded.
  initial begin : monitor
    int         cnt;
    int         idx;
    logic [7:0] want;
    logic [7:0] dec;
    bit         bad;
    logic       expb;
    cnt = 0;
    want = 8'h00;
    dec = 8'h00;
    bad = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        mon_act = 1'b0;
      end else begin
        if (!mon_act && tx === 1'b0) begin
          mon_act = 1'b1;
          cnt = 0;
          bad = 1'b0;
          dec = 8'h00;
          starts.push_back(cyc);
          chk("frame_expected", exp_q.size() > 0, 1);
          if (exp_q.size() > 0) want = exp_q.pop_front();
          else want = 8'h00;
        end else if (mon_act) begin
          cnt++;
        end
        if (mon_act) begin
          idx = cnt / CPB;
          if (idx == 0) expb = 1'b0;
          else if (idx == 9) expb = 1'b1;
          else expb = want[idx-1];
          if (tx !== expb) bad = 1'b1;
          if ((cnt % CPB) == CPB/2 && idx >= 1 && idx <= 8) dec[idx-1] = tx;
          if (cnt == 10*CPB - 1) begin
            chk("frame_shape", bad, 0);
            chk("frame_decode", dec, want);
            mon_act = 1'b0;
          end
        end
      end
    end
  end

  initial begin : stim
    int         a0, a;
    int         r;
    int         s0;
    int         acc[6];
    bit         bad;
    logic [6:0] dec7;
    longint     t0, t1, t2, t3;
    logic [7:0] hi_str[4];

    rst = 1'b1; rst2 = 1'b1;
    tx_valid = 1'b0; tx_data = 8'h00;
    tx_valid2 = 1'b0; tx_data2 = 8'h00;
    hi_str[0] = 8'h48; hi_str[1] = 8'h69; hi_str[2] = 8'h0D; hi_str[3] = 8'h0A;

    repeat (3) @(negedge clk);
    chk("rst_tx", tx, 1);
    chk("rst_tx_ready", tx_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_fifo_count", fifo_count, 0);
    chk("rst_tx2", tx2, 1);

    // Single byte 0x55, pushed on the first edge after reset release
    @(negedge clk);
    rst = 1'b0; rst2 = 1'b0;
    r = cyc;
    send(8'h55, 4, a0);
    chk("t1_first_edge_accept", a0, r + 1);
    chk("t1_count_after_push", fifo_count, 1);
    chk("t1_tx_idle_before_pop", tx, 1);
    chk("t1_busy_after_push", busy, 1);
    @(negedge clk);
    chk("t1_tx_start_low", tx, 0);
    chk("t1_count_after_pop", fifo_count, 0);
    repeat (CPB*10 - 1) @(negedge clk);
    chk("t1_busy_end_stop", busy, 1);
    chk("t1_tx_stop_high", tx, 1);
    @(negedge clk);
    chk("t1_busy_fall", busy, 0);
    chk("t1_tx_idle_after", tx, 1);

    // "Hi\r\n" back to back
    repeat (5) @(negedge clk);
    s0 = starts.size();
    send(hi_str[0], 4, a0);
    for (int i = 1; i < 4; i++) send(hi_str[i], 4, a);
    chk("t2_count_peak", fifo_count, 3);
    wait_idle(800);
    chk("t2_frame_count", starts.size() - s0, 4);
    if (starts.size() >= s0 + 4) begin
      chk("t2_first_start", starts[s0], a0 + 1);
      for (int k = 1; k < 4; k++) chk("t2_contiguous", starts[s0+k] - starts[s0+k-1], 10*CPB);
    end

    // Six bytes with tx_valid held: back-pressure at full
    repeat (3) @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      send(8'(i + 1), 300, a);
      acc[i] = a;
      if (i == 4) begin
        chk("t3_count_full", fifo_count, DEPTH);
        chk("t3_ready_low_full", tx_ready, 0);
      end
    end
    chk("t3_fill_edges", acc[4] - acc[0], 4);
    chk("t3_sixth_accept_edge", acc[5] - acc[0], 10*CPB + 2);
    wait_idle(1200);

    // Reset at cycle 40 of a 0xA5 frame with two bytes queued
    repeat (3) @(negedge clk);
    send(8'hA5, 4, a0);
    send(8'h11, 4, a);
    send(8'h22, 4, a);
    repeat (39) @(negedge clk);
    chk("t4_mid_frame_low", tx, 0);
    chk("t4_queued", fifo_count, 2);
    #1;
    rst = 1'b1;
    exp_q.delete();
    #1;
    chk("t4_async_tx", tx, 1);
    chk("t4_async_count", fifo_count, 0);
    chk("t4_async_busy", busy, 0);
    chk("t4_async_ready", tx_ready, 1);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    bad = 1'b0;
    repeat (200) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0) bad = 1'b1;
    end
    chk("t4_quiet_after_rst", bad, 0);
    send(8'h3C, 4, a);
    wait_idle(400);

    // Default parameters: 0x0D at 50 MHz, 5208 clocks per bit
    chk("t5_idle_tx2", tx2, 1);
    chk("t5_idle_busy2", busy2, 0);
    tx_data2 = 8'h0D;
    tx_valid2 = 1'b1;
    @(negedge clk);
    tx_valid2 = 1'b0;
    chk("t5_busy2", busy2, 1);
    wait_tx2(1'b0, 4, t0);
    wait_tx2(1'b1, 6000, t1);
    chk("t5_start_bit_ns", t1 - t0, 104160);
    wait_tx2(1'b0, 6000, t2);
    chk("t5_bit0_ns", t2 - t1, 104160);
    repeat (2604) @(negedge clk);
    dec7[0] = tx2;
    for (int k = 1; k < 7; k++) begin
      repeat (5208) @(negedge clk);
      dec7[k] = tx2;
    end
    chk("t5_decode_bits7_1", dec7, 7'h06);
    repeat (5208) @(negedge clk);
    chk("t5_stop_high", tx2, 1);
    r = 0;
    while (busy2 !== 1'b0 && r < 6000) begin
      @(negedge clk);
      r++;
    end
    if (r >= 6000) fail_now("t5_busy2_fall", 6000);
    t3 = longint'($time);
    chk("t5_tail_ns", t3 - t2, 833280);

    chk("scoreboard_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo.md
UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 5208, meaning clk cycles per serial bit (50 MHz / 9600 baud); legal range 4..65535.
REQ-002 SHALL have parameter FIFO_DEPTH, default 16, meaning transmit FIFO entries; power of two, 2..256.
REQ-003 SHALL have port clk  input  1  single system clock, all state on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port tx_data  input  8  byte to transmit.
REQ-006 SHALL have port tx_valid  input  1  tx_data valid this cycle.
REQ-007 SHALL have port tx_ready  output  1  FIFO can accept a byte this cycle.
REQ-008 SHALL have port tx  output  1  serial line, idle high, 8N1 frames.
REQ-009 SHALL have port busy  output  1  a frame is on the line or FIFO non-empty.
REQ-010 SHALL have port fifo_count  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Function
REQ-011 Byte SHALL be accepted on a rising edge where tx_valid && tx_ready; it is written to the FIFO tail that edge.
REQ-012 tx_ready SHALL equal (fifo_count < FIFO_DEPTH), combinational from registered count; tx_valid while full is ignored, no data lost from FIFO.
REQ-013 tx_data SHALL be sampled only at the accept edge; later changes do not affect the queued byte.
REQ-014 FSM SHALL have states IDLE, START, DATA, STOP.
REQ-015 IDLE: tx=1; if FIFO non-empty at an edge, pop head into shift register, clear bit counter and baud counter, go START.
REQ-016 START: tx=0 for exactly CLKS_PER_BIT cycles, then DATA.
REQ-017 DATA: drive shift register bit 0 (LSB first), each bit exactly CLKS_PER_BIT cycles; shift right after each bit; after bit 7 go STOP.
REQ-018 STOP: tx=1 for exactly CLKS_PER_BIT cycles; at end, if FIFO non-empty pop and go START directly (zero idle gap), else go IDLE.
REQ-019 tx SHALL be a registered output (glitch-free).
REQ-020 Latency: byte accepted at edge N into empty FIFO with FSM in IDLE SHALL pop at edge N+1; tx falls after edge N+1.
REQ-021 Frame length SHALL be exactly 10*CLKS_PER_BIT cycles; back-to-back frames contiguous.
REQ-022 Simultaneous push and pop in one cycle SHALL leave fifo_count unchanged and both operations SHALL succeed, including at count==FIFO_DEPTH (pop frees, but tx_ready already 0 that cycle -> no push).
REQ-023 FIFO pointers SHALL wrap modulo FIFO_DEPTH; ordering strictly FIFO.
REQ-024 busy SHALL be 1 when state != IDLE or fifo_count != 0.
REQ-025 Baud counter width SHALL be $clog2(CLKS_PER_BIT); no drift across frames.

Reset
REQ-026 While rst=1 and asynchronously on assertion: state=IDLE, tx=1, fifo_count=0, tx_ready=1, busy=0, pointers and counters cleared.
REQ-027 Reset mid-frame SHALL abort the frame immediately (tx=1) and discard all queued bytes; no partial frame resumes after release.
REQ-028 First accept SHALL be possible on the first rising edge after rst deasserts.

Verification (CLKS_PER_BIT=16, FIFO_DEPTH=4 unless stated)
REQ-029 Single byte 0x55 accepted at edge N -> tx low after edge N+1 for 16 cycles, bits 1,0,1,0,1,0,1,0 each 16 cycles, stop high 16 cycles, busy falls after 160 cycles; monitor decodes 0x55.
REQ-030 Push "Hi\r\n" (0x48,0x69,0x0D,0x0A) consecutively -> four contiguous 160-cycle frames, no idle gap, decoded in order, fifo_count peaks at 3.
REQ-031 Hold tx_valid for 6 bytes 0x01..0x06 during first frame -> tx_ready drops when count==4, bytes accepted only when ready; all accepted bytes transmitted in order, none duplicated.
REQ-032 Assert rst for 2 cycles at cycle 40 of a 0xA5 frame with 2 bytes queued -> tx=1 immediately, fifo_count=0, busy=0; no further frames until new push.
REQ-033 Default parameters, byte 0x0D at 50 MHz -> each bit 104160 ns (5208 cycles), within 0.1% of 9600-baud nominal; monitor decodes 0x0D with stop bit high.
